// File: rtl/btn_reset_ctrl.sv
// btn_reset_ctrl: synchronizes and debounces the active-low usr_btn pad and
// classifies each press. A short press yields a one-cycle short_press pulse.
// A long press drives the registered, active-low rst_n low for
// RST_PULSE_CYCLES to request the bootloader.
//
// Ports:
//   clk48        48 MHz system clock
//   rst          asynchronous active-high reset
//   usr_btn      raw pad input, asynchronous, 0 = pressed
//   btn_level    debounced button state, 1 = pressed
//   short_press  one-cycle pulse on release of a short press
//   long_pending high while a long press is armed (LED indicator)
//   rst_n        registered reset request to the board, active-low
//
// Build option BTN_RESET_CTRL_IMMEDIATE_EN: when defined, reset is requested
// one clock after the hold threshold, even with the button still held. The
// ARMED state is not built and long_pending is tied to 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | button released, or waiting for release after a reset pulse
// PRESSED | debounced press in progress, hold time below LONG_CYCLES
// ARMED   | hold time reached LONG_CYCLES, reset fires on release
// RESET   | rst_n held low for RST_PULSE_CYCLES, button ignored

module btn_reset_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 480000,
    parameter int LONG_CYCLES      = 96000000,
    parameter int RST_PULSE_CYCLES = 4800
) (
    input  logic clk48,
    input  logic rst,
    input  logic usr_btn,
    output logic btn_level,
    output logic short_press,
    output logic long_pending,
    output logic rst_n
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam int PW = $clog2(RST_PULSE_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

`ifdef BTN_RESET_CTRL_IMMEDIATE_EN
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_RESET} state_t;
`else
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_ARMED, S_RESET} state_t;
`endif

    state_t          state, state_next;
    logic            sync1, sync2;
    logic            btn_sync;
    logic [DW-1:0]   deb_cnt;
    logic [HW-1:0]   hold_cnt;
    logic [PW-1:0]   pulse_cnt;
    logic            need_release;
    logic            short_next;

    assign btn_sync = ~sync2;

    // Synchronizer and debouncer. The counter holds the number of
    // consecutive disagreeing cycles already seen, so the level flips on
    // the DEBOUNCE_CYCLES-th one.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            deb_cnt   <= '0;
            btn_level <= 1'b0;
        end else begin
            sync1 <= usr_btn;
            sync2 <= sync1;
            if (btn_sync == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt   <= '0;
                btn_level <= ~btn_level;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Hold counter counts cycles with btn_level high and is zero whenever the
    // button is released, so every press into PRESSED starts from a clean
    // count. Its value after a clock equals the press length so far.
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (!btn_level) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        short_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (btn_level && !need_release) state_next = S_PRESSED;
            end
            S_PRESSED: begin
`ifdef BTN_RESET_CTRL_IMMEDIATE_EN
                // Threshold was reached on the previous clock.
                if (hold_cnt == HOLD_MAX) begin
                    state_next = S_RESET;
                end else if (!btn_level) begin
                    state_next = S_IDLE;
                    short_next = 1'b1;
                end
`else
                // Release is tested first so a release coinciding with the
                // threshold clock stays a short press.
                if (!btn_level) begin
                    state_next = S_IDLE;
                    short_next = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_next = S_ARMED;
                end
`endif
            end
`ifndef BTN_RESET_CTRL_IMMEDIATE_EN
            S_ARMED: begin
                if (!btn_level) state_next = S_RESET;
            end
`endif
            S_RESET: begin
                if (pulse_cnt == PULSE_LAST) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            pulse_cnt    <= '0;
            need_release <= 1'b0;
            short_press  <= 1'b0;
            rst_n        <= 1'b1;
        end else begin
            state       <= state_next;
            short_press <= short_next;
            rst_n       <= (state_next != S_RESET);
            if (state == S_RESET && state_next == S_RESET) begin
                pulse_cnt <= pulse_cnt + 1'b1;
            end else begin
                pulse_cnt <= '0;
            end
            // A press still held after the pulse must be released before a
            // new press can be recognized.
            if (state == S_RESET && state_next == S_IDLE) begin
                need_release <= 1'b1;
            end else if (!btn_level) begin
                need_release <= 1'b0;
            end
        end
    end

`ifdef BTN_RESET_CTRL_IMMEDIATE_EN
    assign long_pending = 1'b0;
`else
    always_ff @(posedge clk48 or posedge rst) begin
        if (rst) begin
            long_pending <= 1'b0;
        end else begin
            long_pending <= (state_next == S_ARMED);
        end
    end
`endif

endmodule

// File: doc/btn_reset_ctrl.md
# btn_reset_ctrl

Button controller for the OrangeCrab board: it synchronizes and debounces `usr_btn`, then classifies each press as short or long. A short press produces a one-cycle event for user logic. A long press drives the registered `rst_n` low for a fixed pulse, which enters the bootloader. The block sits between the `usr_btn` pad and the top-level `rst_n` pin, and replaces the direct one-flop button-to-reset path.

## Interface
- `DEBOUNCE_CYCLES`, 480000: number of consecutive stable cycles (10 ms at 48 MHz) required before the debounced level changes; must be ≥1.
- `LONG_CYCLES`, 96000000: hold time (2 s) after which a press is classed as long; must be > `DEBOUNCE_CYCLES`.
- `RST_PULSE_CYCLES`, 4800: width of the `rst_n` low pulse (100 µs); must be ≥1.
- `clk48` in 1: 48 MHz system clock.
- `rst` in 1: asynchronous, active-high reset.
- `usr_btn` in 1: raw pad input, asynchronous, active-low (0 = pressed).
- `btn_level` out 1: debounced button state (1 = pressed).
- `short_press` out 1: one-cycle pulse on release of a short press.
- `long_pending` out 1: high while a long press is armed; intended for the LED indicator.
- `rst_n` out 1: registered reset request to the board, active-low.

## Operation
- Synchronizer: 2 flops on `usr_btn`, both reset to 1 (released).
- Debouncer: compares the synchronized value against `btn_level`.
  - Counter increments while they disagree and clears to 0 when they agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, `btn_level` toggles and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Hold counter: width `$clog2(LONG_CYCLES+1)`, saturates at `LONG_CYCLES`, cleared on entry to PRESSED.
- FSM states: IDLE, PRESSED, ARMED, RESET.
  - IDLE → PRESSED when `btn_level` rises.
  - PRESSED → IDLE when `btn_level` falls before the hold count reaches `LONG_CYCLES`; `short_press` = 1 for that one cycle.
  - PRESSED → ARMED when the hold count reaches `LONG_CYCLES`; `long_pending` = 1 while in ARMED.
  - ARMED → RESET when `btn_level` falls.
  - RESET: `rst_n` = 0 for exactly `RST_PULSE_CYCLES` cycles, then → IDLE with `rst_n` = 1.
  - In RESET, `btn_level` activity is ignored. A press still active on return to IDLE does not start a new press until `btn_level` has been seen low.
- Reset values: `btn_level` = 0, `short_press` = 0, `long_pending` = 0, `rst_n` = 1, FSM = IDLE, all counters = 0.
- `rst` asserted mid-operation (including during a RESET pulse) returns everything to reset values immediately. `rst_n` goes to 1 asynchronously.
- All outputs are registered. There are no combinational paths from `usr_btn` to any output.

## Timing
- `btn_level` changes `DEBOUNCE_CYCLES` + 2 clocks after `usr_btn` settles to a new stable value.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- `long_pending` rises `LONG_CYCLES` clocks after `btn_level` rises.
- `short_press` asserts on the clock after `btn_level` falls while the FSM is in PRESSED.
- `rst_n` falls on the clock after `btn_level` falls while the FSM is in ARMED.
- A press exactly `LONG_CYCLES`−1 clocks long is short; `LONG_CYCLES` or longer is long.
- If `btn_level` falls on the same cycle the hold count reaches `LONG_CYCLES`, the release wins and the press is short.

## Configuration
- `BTN_RESET_CTRL_IMMEDIATE_EN` defined:
  - PRESSED goes directly to RESET when the hold count reaches `LONG_CYCLES`; the ARMED state is not built.
  - `long_pending` is tied to 0.
  - `rst_n` falls one clock after the threshold, even while the button is still held.
- Undefined: the block behaves as described above, and reset is requested on release.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `RST_PULSE_CYCLES`=3.
- Reset: assert `rst` with `usr_btn`=1 → `btn_level`=0, `short_press`=0, `long_pending`=0, `rst_n`=1; counters and FSM at reset values.
- Glitch rejection: `usr_btn` low for 3 clocks → `btn_level` stays 0 and no outputs change.
- Short press: `usr_btn` low for 10 clocks → `btn_level` high 6 clocks after the fall; after release, exactly one `short_press` pulse; `rst_n` stays 1.
- Long press:
  - `usr_btn` held low for 40 clocks → `long_pending` rises 20 clocks after `btn_level` rises.
  - On release, once `btn_level` falls, `rst_n`=0 for exactly 3 clocks and `long_pending` clears.
- Boundary and abort:
  - A press giving `btn_level` high for exactly 19 clocks → `short_press` pulse, no reset.
  - Assert `rst` during the `rst_n` pulse → `rst_n`=1 immediately and FSM = IDLE.
- Immediate mode (`BTN_RESET_CTRL_IMMEDIATE_EN` defined), button held indefinitely → `rst_n` low for 3 clocks starting 21 clocks after `btn_level` rises; `long_pending` stays 0.
